// File: rtl/mem_arb_pkg.sv
// Shared definitions for the SRAM arbiter: FSM encoding, default sizing
// and the byte-lane decode used for CPU stores.
package mem_arb_pkg;

  localparam int DEF_WAIT      = 2;
  localparam int DEF_VID_BURST = 4;
  localparam int DEF_ADR_W     = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_VID  = 2'd2
  } state_t;

  // Active-low lane enables: a byte store drives only the addressed lane.
  function automatic logic [3:0] lane_be_n(input logic [1:0] lane, input logic ben);
    logic [3:0] onehot;
    onehot = 4'b0001 << lane;
    return ben ? ~onehot : 4'b0000;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the CPU data port, video DMA port and SRAM pins of the arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADR_W = DEF_ADR_W
);
  logic             cpu_req;
  logic             cpu_wr;
  logic             cpu_ben;
  logic [23:0]      cpu_adr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             stall_x;
  logic             vid_req;
  logic [ADR_W-1:0] vid_adr;
  logic             vid_ack;
  logic [31:0]      vid_rdata;
  logic [ADR_W-1:0] sram_adr;
  logic [3:0]       sram_be_n;
  logic             sram_we_n;
  logic             sram_oe_n;
  logic [31:0]      sram_dout;
  logic             sram_dout_en;
  logic [31:0]      sram_din;

  modport slave (
    input  cpu_req, cpu_wr, cpu_ben, cpu_adr, cpu_wdata, vid_req, vid_adr, sram_din,
    output cpu_rdata, stall_x, vid_ack, vid_rdata,
    output sram_adr, sram_be_n, sram_we_n, sram_oe_n, sram_dout, sram_dout_en
  );

  modport master (
    output cpu_req, cpu_wr, cpu_ben, cpu_adr, cpu_wdata, vid_req, vid_adr, sram_din,
    input  cpu_rdata, stall_x, vid_ack, vid_rdata,
    input  sram_adr, sram_be_n, sram_we_n, sram_oe_n, sram_dout, sram_dout_en
  );
endinterface

// File: rtl/sram_cycle.sv
// One WAIT-cycle asynchronous SRAM access: registered strobes, a down-counter,
// a last-cycle flag and the word captured at the end of a read.
module sram_cycle
  import mem_arb_pkg::*;
#(
  parameter int WAIT  = DEF_WAIT,
  parameter int ADR_W = DEF_ADR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADR_W-1:0] adr,
  input  logic             wr,
  input  logic [3:0]       be_n,
  input  logic [31:0]      wdata,
  output logic             last,
  output logic [31:0]      rdata,
  output logic [ADR_W-1:0] sram_adr,
  output logic [3:0]       sram_be_n,
  output logic             sram_we_n,
  output logic             sram_oe_n,
  output logic [31:0]      sram_dout,
  output logic             sram_dout_en,
  input  logic [31:0]      sram_din
);
  localparam int CW = $clog2(WAIT);

  logic          busy_reg;
  logic          wr_reg;
  logic [CW-1:0] cnt_reg;

  assign last = busy_reg && (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg     <= 1'b0;
      wr_reg       <= 1'b0;
      cnt_reg      <= '0;
      rdata        <= '0;
      sram_adr     <= '0;
      sram_be_n    <= 4'hF;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
    end else if (start) begin
      busy_reg     <= 1'b1;
      wr_reg       <= wr;
      cnt_reg      <= CW'(WAIT - 1);
      sram_adr     <= adr;
      sram_be_n    <= be_n;
      sram_we_n    <= ~wr;
      sram_oe_n    <= wr;
      sram_dout_en <= wr;
      if (wr) sram_dout <= wdata;
    end else if (busy_reg) begin
      cnt_reg <= cnt_reg - CW'(1);
      // we_n rises one cycle early so address and data are held past the strobe
      if (cnt_reg == CW'(1)) sram_we_n <= 1'b1;
      if (last) begin
        busy_reg     <= 1'b0;
        sram_be_n    <= 4'hF;
        sram_we_n    <= 1'b1;
        sram_oe_n    <= 1'b1;
        sram_dout_en <= 1'b0;
        if (!wr_reg) rdata <= sram_din;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 32-bit async SRAM between the CPU data port and video DMA;
// video has priority up to VID_BURST consecutive grants while the CPU waits.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT      = DEF_WAIT,
  parameter int VID_BURST = DEF_VID_BURST,
  parameter int ADR_W     = DEF_ADR_W
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  localparam int VCW = $clog2(VID_BURST + 1);
  localparam logic [VCW-1:0] VC_MAX = VCW'(VID_BURST);

  state_t           state_reg, state_next;
  logic [VCW-1:0]   vcnt_reg, vcnt_next;
  logic             cpu_done_reg, vid_ack_reg, cpu_rd_reg;
  logic [31:0]      cpu_hold_reg, vid_hold_reg;
  logic             elig, vid_grant, cpu_grant, start, last;
  logic [ADR_W-1:0] acc_adr;
  logic             acc_wr;
  logic [3:0]       acc_be_n;
  logic [31:0]      rdata;
  logic             unused_adr_hi;

  assign unused_adr_hi = ^bus.cpu_adr[23:ADR_W+2];

  assign elig        = bus.cpu_req & ~cpu_done_reg;
  assign bus.stall_x = elig;

  always_comb begin
    state_next = state_reg;
    vcnt_next  = vcnt_reg;
    vid_grant  = 1'b0;
    cpu_grant  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.vid_req && (vcnt_reg < VC_MAX || !elig)) begin
          vid_grant  = 1'b1;
          state_next = ST_VID;
          if (vcnt_reg < VC_MAX) vcnt_next = vcnt_reg + VCW'(1);
        end else if (elig) begin
          cpu_grant  = 1'b1;
          state_next = ST_CPU;
          vcnt_next  = '0;
        end else if (!bus.vid_req) begin
          vcnt_next = '0;
        end
      end
      ST_CPU, ST_VID: if (last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign start    = vid_grant | cpu_grant;
  assign acc_adr  = vid_grant ? bus.vid_adr : bus.cpu_adr[ADR_W+1:2];
  assign acc_wr   = cpu_grant & bus.cpu_wr;
  assign acc_be_n = acc_wr ? lane_be_n(bus.cpu_adr[1:0], bus.cpu_ben) : 4'h0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      vcnt_reg     <= '0;
      cpu_done_reg <= 1'b0;
      vid_ack_reg  <= 1'b0;
      cpu_rd_reg   <= 1'b0;
      cpu_hold_reg <= '0;
      vid_hold_reg <= '0;
    end else begin
      state_reg    <= state_next;
      vcnt_reg     <= vcnt_next;
      cpu_done_reg <= (state_reg == ST_CPU) && last;
      vid_ack_reg  <= (state_reg == ST_VID) && last;
      if (cpu_grant) cpu_rd_reg <= ~bus.cpu_wr;
      if (cpu_done_reg && cpu_rd_reg) cpu_hold_reg <= rdata;
      if (vid_ack_reg) vid_hold_reg <= rdata;
    end
  end

  // The shared capture register is valid in the done/ack cycle; each port keeps its own copy after.
  assign bus.cpu_rdata = (cpu_done_reg && cpu_rd_reg) ? rdata : cpu_hold_reg;
  assign bus.vid_rdata = vid_ack_reg ? rdata : vid_hold_reg;
  assign bus.vid_ack   = vid_ack_reg;

  sram_cycle #(.WAIT(WAIT), .ADR_W(ADR_W)) u_cycle (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .adr          (acc_adr),
    .wr           (acc_wr),
    .be_n         (acc_be_n),
    .wdata        (bus.cpu_wdata),
    .last         (last),
    .rdata        (rdata),
    .sram_adr     (bus.sram_adr),
    .sram_be_n    (bus.sram_be_n),
    .sram_we_n    (bus.sram_we_n),
    .sram_oe_n    (bus.sram_oe_n),
    .sram_dout    (bus.sram_dout),
    .sram_dout_en (bus.sram_dout_en),
    .sram_din     (bus.sram_din)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random CPU/video traffic,
// checked every cycle against a transaction-level model with its own memory.
module tb_mem_arbiter;
  localparam int WAIT  = 2;
  localparam int VB    = 4;
  localparam int ADR_W = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADR_W(ADR_W)) bus();
  mem_arbiter #(.WAIT(WAIT), .VID_BURST(VB), .ADR_W(ADR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] sram_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [31:0] mem_init(input int i);
    if (i == 256) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Asynchronous SRAM: reads follow address while oe_n is low, writes land while we_n is low.
  assign bus.sram_din = bus.sram_oe_n ? 32'h0 : sram_mem[bus.sram_adr[9:0]];
  initial begin
    for (int i = 0; i < 1024; i++) sram_mem[i] = mem_init(i);
    forever begin
      @(posedge clk);
      if (bus.sram_we_n === 1'b0)
        for (int i = 0; i < 4; i++)
          if (!bus.sram_be_n[i]) sram_mem[bus.sram_adr[9:0]][8*i +: 8] = bus.sram_dout[8*i +: 8];
    end
  end

  // Reference model: one access in flight, m_busy counts its remaining cycles.
  int m_busy, m_vcnt;
  bit m_vid, m_wr, m_done, m_ack, started;
  logic [ADR_W-1:0] m_adr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata, m_cpu_rdata, m_vid_rdata;

  initial begin
    bit nd, na, elig;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem_init(i);
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (!rst) begin
        m_busy = 0; m_vcnt = 0; m_done = 0; m_ack = 0; m_vid = 0; m_wr = 0;
        m_adr = '0; m_be = 4'h0; m_wdata = '0; m_cpu_rdata = '0; m_vid_rdata = '0;
      end else begin
        nd = 0; na = 0;
        if (m_busy > 0) begin
          m_busy--;
          if (m_busy == 0) begin
            if (m_vid) begin
              m_vid_rdata = ref_mem[m_adr[9:0]]; na = 1;
            end else begin
              nd = 1;
              if (m_wr) begin
                for (int i = 0; i < 4; i++)
                  if (!m_be[i]) ref_mem[m_adr[9:0]][8*i +: 8] = m_wdata[8*i +: 8];
              end else m_cpu_rdata = ref_mem[m_adr[9:0]];
            end
          end
        end else begin
          elig = bus.cpu_req && !m_done;
          if (bus.vid_req && (m_vcnt < VB || !elig)) begin
            m_vid = 1; m_wr = 0; m_adr = bus.vid_adr; m_be = 4'h0; m_busy = WAIT;
            m_vcnt = (m_vcnt < VB) ? m_vcnt + 1 : VB;
          end else if (elig) begin
            m_vid = 0; m_wr = bus.cpu_wr; m_adr = bus.cpu_adr[ADR_W+1:2]; m_wdata = bus.cpu_wdata;
            m_be = (bus.cpu_wr && bus.cpu_ben) ? ~(4'b0001 << bus.cpu_adr[1:0]) : 4'h0;
            m_busy = WAIT; m_vcnt = 0;
          end else if (!bus.vid_req) m_vcnt = 0;
        end
        m_done = nd; m_ack = na;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int k;
    if (started) begin
      chk("stall_x", 32'(bus.stall_x), 32'(bus.cpu_req & ~m_done));
      chk("vid_ack", 32'(bus.vid_ack), 32'(m_ack));
      chk("cpu_rdata", bus.cpu_rdata, m_cpu_rdata);
      chk("vid_rdata", bus.vid_rdata, m_vid_rdata);
      chk("sram_adr", 32'(bus.sram_adr), 32'(m_adr));
      if (m_busy > 0) begin
        k = WAIT - m_busy + 1;
        chk("acc_oe_n", 32'(bus.sram_oe_n), 32'(m_wr));
        chk("acc_we_n", 32'(bus.sram_we_n), 32'(!(m_wr && k < WAIT)));
        chk("acc_dout_en", 32'(bus.sram_dout_en), 32'(m_wr));
        chk("acc_be_n", 32'(bus.sram_be_n), 32'(m_be));
        if (m_wr) chk("acc_dout", bus.sram_dout, m_wdata);
      end else begin
        chk("idle_oe_n", 32'(bus.sram_oe_n), 32'd1);
        chk("idle_we_n", 32'(bus.sram_we_n), 32'd1);
        chk("idle_dout_en", 32'(bus.sram_dout_en), 32'd0);
        chk("idle_be_n", 32'(bus.sram_be_n), 32'hF);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_set(input bit req, input bit wr, input bit ben,
                         input logic [23:0] adr, input logic [31:0] wd);
    bus.cpu_req = req; bus.cpu_wr = wr; bus.cpu_ben = ben;
    bus.cpu_adr = adr; bus.cpu_wdata = wd;
  endtask

  task automatic new_req();
    cpu_set(1'b1, 1'($urandom_range(1)), 1'($urandom_range(1)),
            24'($urandom_range(4095)), $urandom);
  endtask

  initial begin
    int n, acks, welow;
    logic [3:0] be_seen;
    bit got;
    cpu_set(1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
    bus.vid_req = 1'b0; bus.vid_adr = '0;
    rst = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    chk("reset_cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("reset_be_n", 32'(bus.sram_be_n), 32'hF);

    // Uncontended word load
    cpu_set(1'b1, 1'b0, 1'b0, 24'h000400, 32'h0); #1;
    n = 0;
    while (bus.stall_x === 1'b1 && n < 50) begin n++; cyc(); end
    chk("load_stall_cycles", 32'(n), 32'd3);
    chk("load_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    cpu_set(1'b0, 1'b0, 1'b0, 24'h0, 32'h0); cyc();

    // Byte store into lane 3
    cpu_set(1'b1, 1'b1, 1'b1, 24'h000403, 32'hAB000000); #1;
    n = 0; welow = 0; be_seen = 4'hF;
    while (bus.stall_x === 1'b1 && n < 50) begin
      if (bus.sram_we_n === 1'b0) begin welow++; be_seen = bus.sram_be_n; end
      n++; cyc();
    end
    chk("store_be_n", 32'(be_seen), 32'h7);
    chk("store_we_low_cycles", 32'(welow), 32'd1);
    cpu_set(1'b0, 1'b0, 1'b0, 24'h0, 32'h0); cyc();
    chk("store_mem", sram_mem[256], 32'hABADBEEF);

    // Back-to-back loads: new address presented in the done cycle
    cpu_set(1'b1, 1'b0, 1'b0, 24'h000400, 32'h0); #1;
    n = 0;
    while (bus.stall_x === 1'b1 && n < 50) begin n++; cyc(); end
    chk("b2b_first_rdata", bus.cpu_rdata, 32'hABADBEEF);
    bus.cpu_adr = 24'h000404; cyc();
    n = 0;
    while (bus.stall_x === 1'b1 && n < 50) begin n++; cyc(); end
    chk("b2b_second_stall", 32'(n), 32'd3);
    chk("b2b_second_rdata", bus.cpu_rdata, mem_init(257));
    cpu_set(1'b0, 1'b0, 1'b0, 24'h0, 32'h0); cyc();

    // Simultaneous requests with video held: burst of 4 then CPU, then video resumes
    bus.vid_req = 1'b1; bus.vid_adr = 18'd5;
    cpu_set(1'b1, 1'b0, 1'b0, 24'h000010, 32'h0); #1;
    n = 0; acks = 0;
    while (bus.stall_x === 1'b1 && n < 50) begin
      if (bus.vid_ack === 1'b1) acks++;
      n++; cyc();
    end
    chk("burst_acks_before_cpu", 32'(acks), 32'd4);
    chk("burst_cpu_wait_bounded", 32'(n <= 4 * (WAIT + 1) + WAIT + 1), 32'd1);
    chk("burst_cpu_rdata", bus.cpu_rdata, mem_init(4));
    cpu_set(1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
    n = 0; got = 0;
    while (!got && n < 10) begin cyc(); got = (bus.vid_ack === 1'b1); n++; end
    chk("video_resumes", 32'(got), 32'd1);
    bus.vid_req = 1'b0;
    repeat (4) cyc();

    // Reset during write access cycle 1 (data equals memory content, so nothing changes)
    cpu_set(1'b1, 1'b1, 1'b0, 24'h000020, ref_mem[8]); cyc();
    chk("abort_we_low", 32'(bus.sram_we_n), 32'd0);
    rst = 1'b0; cyc();
    chk("abort_we_n", 32'(bus.sram_we_n), 32'd1);
    chk("abort_dout_en", 32'(bus.sram_dout_en), 32'd0);
    chk("abort_no_done", 32'(bus.stall_x), 32'd1);
    cpu_set(1'b0, 1'b0, 1'b0, 24'h0, 32'h0); cyc();
    rst = 1'b1; cyc();
    cpu_set(1'b1, 1'b0, 1'b0, 24'h000400, 32'h0); #1;
    n = 0;
    while (bus.stall_x === 1'b1 && n < 50) begin n++; cyc(); end
    chk("post_reset_stall", 32'(n), 32'd3);
    chk("post_reset_rdata", bus.cpu_rdata, 32'hABADBEEF);
    cpu_set(1'b0, 1'b0, 1'b0, 24'h0, 32'h0); cyc();

    // Random traffic: CPU holds each request until its done cycle
    for (int c = 0; c < 3000; c++) begin
      if (bus.cpu_req && !bus.stall_x) begin
        if ($urandom_range(1) == 1) new_req();
        else bus.cpu_req = 1'b0;
      end else if (!bus.cpu_req && $urandom_range(3) == 0) new_req();
      bus.vid_req = ($urandom_range(2) != 0);
      bus.vid_adr = ADR_W'($urandom_range(1023));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 32-bit asynchronous SRAM between the RISC5 processor data port and the video refresh DMA.
- Serialises their accesses and generates the processor's stallX.
- The video port has priority, bounded by a burst limit, so the CPU is never starved.
- Sits between the CPU/video controller and the board SRAM pins.

Parameters:
- WAIT, 2, SRAM access length in clock cycles per word (minimum 2).
- VID_BURST, 4, maximum consecutive video grants while a CPU request is pending (minimum 1).
- ADR_W, 18, SRAM word-address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Synchronous, active-low (0 = reset).
- cpu_req  in  1  raw CPU load/store pending (LDR|STR and not yet completed). Held, with its attributes, while stall_x=1.
- cpu_wr  in  1  1 = store, 0 = load.
- cpu_ben  in  1  byte access.
- cpu_adr  in  24  CPU byte address.
- cpu_wdata  in  32  store data, already lane-positioned by the CPU.
- cpu_rdata  out  32  load data, raw 32-bit word; lane extraction is done by the CPU.
- stall_x  out  1  stall to the CPU (stallX).
- vid_req  in  1  video word request.
- vid_adr  in  ADR_W  video word address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_rdata  out  32  video word.
- sram_adr  out  ADR_W  SRAM word address.
- sram_be_n  out  4  byte enables, active-low.
- sram_we_n  out  1  write strobe, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_dout  out  32  write data.
- sram_dout_en  out  1  tristate enable for sram_dout.
- sram_din  in  32  read data.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State IDLE; done flags and vcnt cleared.
  - Outputs: sram_we_n=1, sram_oe_n=1, sram_dout_en=0, sram_be_n=4'hF, sram_adr=0, vid_ack=0, cpu_rdata=0, vid_rdata=0.
  - Reset mid-access aborts the access: no ack, no done, we_n high from the next edge.
- stall_x (combinational) = cpu_req & ~cpu_done. No other combinational input-to-output paths exist.
- FSM states:
  - IDLE: grant decision, registered. Video is granted if vid_req & (vcnt<VID_BURST | ~cpu_req_eligible). Otherwise CPU is granted if cpu_req_eligible. cpu_req_eligible = cpu_req & ~cpu_done.
  - CPU and VID: access states lasting exactly WAIT cycles, counted by a down-counter.
  - Both return to IDLE, with the CPU access raising cpu_done and the video access raising vid_ack for the following cycle.
- Grants are evaluated every cycle in IDLE, including the done/ack cycle. Back-to-back accesses leave no idle gap beyond the done/ack cycle.
- CPU access:
  - sram_adr = cpu_adr[ADR_W+1:2].
  - Read: sram_oe_n=0, sram_be_n=0000.
  - Write: sram_dout=cpu_wdata, sram_dout_en=1. sram_be_n=0000 for a word, or ~onehot(cpu_adr[1:0]) if cpu_ben.
  - Write timing: sram_we_n=0 in access cycles 1..WAIT-1 and 1 in the last cycle (address/data hold).
  - Read data: sram_din is captured into cpu_rdata at the end of the last access cycle. cpu_rdata then holds until the next CPU read.
- Done cycle:
  - cpu_done=1 for exactly one cycle, so stall_x=0 and the CPU consumes cpu_rdata / retires.
  - cpu_req is ignored during that cycle; a new request is accepted the cycle after.
- Latency, uncontended: cpu_req rises in cycle t → stall_x high t..t+WAIT, low at t+WAIT+1. With WAIT=2 that is 3 stall cycles.
- Video access:
  - Read only, all lanes enabled.
  - vid_rdata is captured at the last access cycle; vid_ack pulses in the next cycle.
  - vid_rdata holds until the next video access.
- vcnt (consecutive video grants):
  - Increments on each video grant, saturating at VID_BURST.
  - Clears on a CPU grant, or in IDLE with vid_req=0.
- Simultaneous requests at IDLE with vcnt<VID_BURST → video first.
- An idle SRAM keeps oe_n=1, we_n=1, dout_en=0, be_n=1111, and the address is held.

Decomposition:
- Package mem_arb_pkg holds:
  - the state encoding (IDLE, CPU, VID);
  - the lane-decode function (adr[1:0], ben → be_n);
  - the default parameter constants.
- One sub-module, sram_cycle:
  - takes start, address, write, be_n and wdata;
  - runs the WAIT-cycle strobe/counter sequence;
  - returns a last-cycle pulse and the captured word.
- The arbiter FSM instantiates one sram_cycle.

Test Plan:
- CPU word load, WAIT=2, no video, mem[0x100]=0xDEADBEEF, cpu_adr=0x000400 → stall_x high 3 cycles, then 1 low cycle with cpu_rdata=0xDEADBEEF.
- CPU byte store, cpu_adr=0x000403, ben=1, wdata=0xAB000000 → sram_be_n=0111, we_n low 1 cycle, mem[0x100]=0xABADBEEF afterwards.
- vid_req held continuously plus cpu_req, VID_BURST=4 → exactly 4 vid_ack pulses, then the CPU access completes, then video resumes. CPU wait ≤ 4*(WAIT+1)+WAIT+1 cycles.
- Back-to-back CPU loads (cpu_req reasserted the cycle after done) → second access starts the cycle after done; no access is issued during the done cycle for the old request.
- rst=0 during a CPU write access cycle 1 → next edge: we_n=1, dout_en=0, no done pulse. After release, state is IDLE and a fresh request completes normally.
- Simultaneous first vid_req and cpu_req at IDLE → video granted first, vid_ack before stall_x drops.
